// File: rtl/rsa_seq_pkg.sv
// rsa_seq_pkg: shared state encoding and default phase timeout for the RSA job sequencer.
package rsa_seq_pkg;

    localparam int DEFAULT_TIMEOUT_CYCLES = 1000000;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_INV_PULSE,
        S_INV_WAIT,
        S_EXP_PULSE,
        S_EXP_WAIT,
        S_RESULT
    } seq_state_t;

endpackage

// File: rtl/rsa_phase_timer.sv
// rsa_phase_timer: counts enabled cycles since the last clear and flags the cycle that
// reaches LIMIT, so the sequencer can abandon a phase that never finishes.
module rsa_phase_timer #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            r_count <= '0;
        else if (i_clear)
            r_count <= '0;
        else if (i_enable && r_count != CW'(LIMIT))
            r_count <= r_count + 1'b1;
    end

    // r_count holds the number of earlier enabled cycles, so LIMIT-1 marks the LIMIT-th one
    assign o_expired = i_enable && (r_count == CW'(LIMIT - 1));

endmodule

// File: rtl/rsa_job_sequencer.sv
// rsa_job_sequencer: accepts RSA jobs, drives the inverter and mod-exp phases of the
// downstream control block, skips the inverter when p,q repeat, and returns the result.
module rsa_job_sequencer
    import rsa_seq_pkg::*;
#(
    parameter int WIDTH          = 128,
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               job_valid,
    output logic               job_ready,
    input  logic [WIDTH-1:0]   job_p,
    input  logic [WIDTH-1:0]   job_q,
    input  logic               job_mode,
    input  logic [2*WIDTH-1:0] job_msg,
    output logic [WIDTH-1:0]   rsa_p,
    output logic [WIDTH-1:0]   rsa_q,
    output logic               rsa_encrypt_decrypt,
    output logic [2*WIDTH-1:0] rsa_msg_in,
    output logic               rsa_reset_inverter,
    output logic               rsa_reset_mod_exp,
    input  logic               rsa_inverter_finish,
    input  logic               rsa_mod_exp_finish,
    input  logic [2*WIDTH-1:0] rsa_msg_out,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [2*WIDTH-1:0] res_msg,
    output logic               res_error
);

    seq_state_t         r_state;
    seq_state_t         w_next;
    logic [WIDTH-1:0]   r_p;
    logic [WIDTH-1:0]   r_q;
    logic               r_mode;
    logic [2*WIDTH-1:0] r_msg;
    logic [WIDTH-1:0]   r_cache_p;
    logic [WIDTH-1:0]   r_cache_q;
    logic               r_cache_valid;
    logic [2*WIDTH-1:0] r_res_msg;
    logic               r_res_error;
    logic               r_first;
    logic               w_wait;
    logic               w_fin;
    logic               w_hit;
    logic               w_expired;
    logic               w_timeout;

    assign w_wait    = (r_state == S_INV_WAIT) || (r_state == S_EXP_WAIT);
    assign w_hit     = r_cache_valid && (r_p == r_cache_p) && (r_q == r_cache_q);
    // r_first masks a finish left over from the previous phase on the first wait cycle
    assign w_fin     = w_wait && !r_first &&
                       ((r_state == S_INV_WAIT) ? rsa_inverter_finish : rsa_mod_exp_finish);
    assign w_timeout = w_wait && !w_fin && w_expired;

    rsa_phase_timer #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .i_clear  ((r_state == S_INV_PULSE) || (r_state == S_EXP_PULSE)),
        .i_enable (w_wait),
        .o_expired(w_expired)
    );

    always_comb begin
        w_next             = r_state;
        job_ready          = (r_state == S_IDLE);
        rsa_reset_inverter = (r_state == S_INV_PULSE);
        rsa_reset_mod_exp  = (r_state == S_EXP_PULSE);
        res_valid          = (r_state == S_RESULT);
        case (r_state)
            S_IDLE:      w_next = job_valid ? S_LOAD : S_IDLE;
            S_LOAD:      w_next = w_hit ? S_EXP_PULSE : S_INV_PULSE;
            S_INV_PULSE: w_next = S_INV_WAIT;
            S_INV_WAIT:  w_next = w_fin ? S_EXP_PULSE : (w_timeout ? S_RESULT : S_INV_WAIT);
            S_EXP_PULSE: w_next = S_EXP_WAIT;
            S_EXP_WAIT:  w_next = (w_fin || w_timeout) ? S_RESULT : S_EXP_WAIT;
            S_RESULT:    w_next = res_ready ? S_IDLE : S_RESULT;
            default:     w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= S_IDLE;
            r_first <= 1'b0;
        end else begin
            r_state <= w_next;
            r_first <= (r_state == S_INV_PULSE) || (r_state == S_EXP_PULSE);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p    <= '0;
            r_q    <= '0;
            r_mode <= 1'b0;
            r_msg  <= '0;
        end else if (job_valid && r_state == S_IDLE) begin
            r_p    <= job_p;
            r_q    <= job_q;
            r_mode <= job_mode;
            r_msg  <= job_msg;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cache_p     <= '0;
            r_cache_q     <= '0;
            r_cache_valid <= 1'b0;
            r_res_msg     <= '0;
            r_res_error   <= 1'b0;
        end else begin
            if (w_fin && r_state == S_INV_WAIT) begin
                r_cache_p     <= r_p;
                r_cache_q     <= r_q;
                r_cache_valid <= 1'b1;
            end
            if (w_fin && r_state == S_EXP_WAIT) begin
                r_res_msg   <= rsa_msg_out;
                r_res_error <= 1'b0;
            end
            // a stalled phase leaves the key state unknown, so it must be recomputed
            if (w_timeout) begin
                r_res_msg     <= '0;
                r_res_error   <= 1'b1;
                r_cache_valid <= 1'b0;
            end
        end
    end

    assign rsa_p               = r_p;
    assign rsa_q               = r_q;
    assign rsa_encrypt_decrypt = r_mode;
    assign rsa_msg_in          = r_msg;
    assign res_msg             = r_res_msg;
    assign res_error           = r_res_error;

endmodule

// File: tb/tb_rsa_job_sequencer.sv
// tb_rsa_job_sequencer: directed checks of the job sequencer against a simple control-block
// model; a second instance with a short timeout exercises the stall path.
module tb_rsa_job_sequencer;

    localparam int W = 128;
    localparam logic [W-1:0]   P1 = 128'd113680897410347;
    localparam logic [W-1:0]   Q1 = 128'd7999808077935876437321;
    localparam logic [W-1:0]   P2 = 128'd8475698667747010771;
    localparam logic [2*W-1:0] M1 = 256'hb37b2800;
    localparam logic [2*W-1:0] M2 = 256'h57e7e100;
    localparam logic [2*W-1:0] M3 = 256'h1234_5678_9abc_def0;

    logic clk = 0;
    logic reset_n = 0;
    logic job_valid = 0, job_ready, job_mode = 0;
    logic [W-1:0] job_p = '0, job_q = '0, rsa_p, rsa_q;
    logic [2*W-1:0] job_msg = '0, rsa_msg_in, msg_out = '0, res_msg;
    logic rsa_ed, inv_pulse, exp_pulse, inv_fin = 0, exp_fin = 0, spur_fin = 0;
    logic res_valid, res_ready = 0, res_error;

    logic t_job_valid = 0, t_job_ready, t_rsa_ed, t_inv_pulse, t_exp_pulse, t_inv_fin = 0;
    logic t_exp_fin = 0, t_res_valid, t_res_ready = 0, t_res_error;
    logic [W-1:0] t_rsa_p, t_rsa_q;
    logic [2*W-1:0] t_rsa_msg_in, t_res_msg;
    logic [2*W-1:0] t_msg_out = '1;

    int n_checks = 0, n_fail = 0;
    int inv_delay = 40, exp_delay = 40, inv_pulses = 0, exp_pulses = 0;

    always #5 clk = ~clk;

    rsa_job_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .reset_n(reset_n),
        .job_valid(job_valid), .job_ready(job_ready),
        .job_p(job_p), .job_q(job_q), .job_mode(job_mode), .job_msg(job_msg),
        .rsa_p(rsa_p), .rsa_q(rsa_q), .rsa_encrypt_decrypt(rsa_ed), .rsa_msg_in(rsa_msg_in),
        .rsa_reset_inverter(inv_pulse), .rsa_reset_mod_exp(exp_pulse),
        .rsa_inverter_finish(inv_fin | spur_fin), .rsa_mod_exp_finish(exp_fin | spur_fin),
        .rsa_msg_out(msg_out),
        .res_valid(res_valid), .res_ready(res_ready), .res_msg(res_msg), .res_error(res_error)
    );

    rsa_job_sequencer #(.WIDTH(W), .TIMEOUT_CYCLES(16)) dut_t (
        .clk(clk), .reset_n(reset_n),
        .job_valid(t_job_valid), .job_ready(t_job_ready),
        .job_p(job_p), .job_q(job_q), .job_mode(job_mode), .job_msg(job_msg),
        .rsa_p(t_rsa_p), .rsa_q(t_rsa_q), .rsa_encrypt_decrypt(t_rsa_ed), .rsa_msg_in(t_rsa_msg_in),
        .rsa_reset_inverter(t_inv_pulse), .rsa_reset_mod_exp(t_exp_pulse),
        .rsa_inverter_finish(t_inv_fin), .rsa_mod_exp_finish(t_exp_fin),
        .rsa_msg_out(t_msg_out),
        .res_valid(t_res_valid), .res_ready(t_res_ready), .res_msg(t_res_msg), .res_error(t_res_error)
    );

    // control-block model: finish pulses D cycles after each start pulse, result = msg*7+3
    initial begin
        int ic, ec;
        ic = 0;
        ec = 0;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                ic = 0; ec = 0; inv_fin = 0; exp_fin = 0;
            end else begin
                inv_fin = 0;
                exp_fin = 0;
                if (ic > 0) begin ic--; inv_fin = (ic == 0); end
                if (ec > 0) begin
                    ec--;
                    if (ec == 0) begin exp_fin = 1; msg_out = rsa_msg_in * 256'd7 + 256'd3; end
                end
                if (inv_pulse) begin ic = inv_delay; inv_pulses++; end
                if (exp_pulse) begin ec = exp_delay; exp_pulses++; end
            end
        end
    end

    task automatic submit(input logic [W-1:0] p, input logic [W-1:0] q, input logic m,
                          input logic [2*W-1:0] msg, output int lat);
        int n;
        n = 0;
        @(negedge clk);
        while (!job_ready && n < 200) begin @(negedge clk); n++; end
        job_p = p; job_q = q; job_mode = m; job_msg = msg; job_valid = 1;
        lat = 0;
        do begin @(negedge clk); job_valid = 0; lat++; end while (!res_valid && lat < 300);
    endtask

    task automatic test_reset;
        #2;
        n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL reset_job_ready: got %b exp 1", job_ready); end
        n_checks++; if (res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b exp 0", res_valid); end
        n_checks++; if (rsa_p !== '0 || rsa_msg_in !== '0) begin n_fail++; $display("FAIL reset_operands: got p=%0h msg=%0h exp 0", rsa_p, rsa_msg_in); end
        n_checks++; if ({inv_pulse, exp_pulse, res_error} !== 3'b0) begin n_fail++; $display("FAIL reset_pulses: got %b exp 000", {inv_pulse, exp_pulse, res_error}); end
        n_checks++; if (res_msg !== '0) begin n_fail++; $display("FAIL reset_res_msg: got %0h exp 0", res_msg); end
        repeat (3) @(negedge clk);
        reset_n = 1;
    endtask

    task automatic test_first_and_hit;
        int lat, i0, e0;
        inv_delay = 40; exp_delay = 40;
        i0 = inv_pulses; e0 = exp_pulses;
        submit(P1, Q1, 1'b0, M1, lat);
        n_checks++; if (lat !== 84) begin n_fail++; $display("FAIL miss_latency: got %0d exp 84", lat); end
        n_checks++; if (res_msg !== M1 * 256'd7 + 256'd3) begin n_fail++; $display("FAIL first_res_msg: got %0h exp %0h", res_msg, M1 * 256'd7 + 256'd3); end
        n_checks++; if (res_error !== 1'b0) begin n_fail++; $display("FAIL first_res_error: got %b exp 0", res_error); end
        n_checks++; if (inv_pulses - i0 !== 1 || exp_pulses - e0 !== 1) begin n_fail++; $display("FAIL first_pulses: got inv=%0d exp=%0d want 1 1", inv_pulses - i0, exp_pulses - e0); end
        n_checks++; if (rsa_p !== P1 || rsa_q !== Q1 || rsa_ed !== 1'b0 || rsa_msg_in !== M1) begin n_fail++; $display("FAIL first_operands: got p=%0h q=%0h msg=%0h", rsa_p, rsa_q, rsa_msg_in); end
        // next job offered in the same cycle the result is taken
        exp_delay = 2;
        i0 = inv_pulses;
        job_p = P1; job_q = Q1; job_mode = 1; job_msg = M2; job_valid = 1; res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        n_checks++; if (job_ready !== 1'b1) begin n_fail++; $display("FAIL no_bypass: got job_ready=%b exp 1", job_ready); end
        n_checks++; if (rsa_msg_in !== M1) begin n_fail++; $display("FAIL operand_hold: got %0h exp %0h", rsa_msg_in, M1); end
        lat = 0;
        do begin @(negedge clk); job_valid = 0; lat++; end while (!res_valid && lat < 300);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL hit_latency: got %0d exp 5", lat); end
        n_checks++; if (inv_pulses - i0 !== 0) begin n_fail++; $display("FAIL hit_no_inverter: got %0d exp 0", inv_pulses - i0); end
        n_checks++; if (res_msg !== M2 * 256'd7 + 256'd3) begin n_fail++; $display("FAIL hit_res_msg: got %0h exp %0h", res_msg, M2 * 256'd7 + 256'd3); end
        n_checks++; if (rsa_ed !== 1'b1) begin n_fail++; $display("FAIL hit_mode: got %b exp 1", rsa_ed); end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
    endtask

    task automatic test_miss;
        int lat, i0;
        inv_delay = 40; exp_delay = 2;
        i0 = inv_pulses;
        submit(P2, Q1, 1'b0, M3, lat);
        n_checks++; if (lat !== 46) begin n_fail++; $display("FAIL newkey_latency: got %0d exp 46", lat); end
        n_checks++; if (inv_pulses - i0 !== 1) begin n_fail++; $display("FAIL newkey_inverter: got %0d exp 1", inv_pulses - i0); end
        n_checks++; if (res_msg !== M3 * 256'd7 + 256'd3) begin n_fail++; $display("FAIL newkey_res_msg: got %0h exp %0h", res_msg, M3 * 256'd7 + 256'd3); end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
    endtask

    task automatic test_back_to_back_stall;
        int lat;
        logic bad;
        exp_delay = 2;
        submit(P2, Q1, 1'b0, M1, lat);
        n_checks++; if (lat !== 5) begin n_fail++; $display("FAIL stall_latency: got %0d exp 5", lat); end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || job_ready !== 1'b0 || res_msg !== M1 * 256'd7 + 256'd3) bad = 1;
        end
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL stall_hold: got unstable result, valid=%b ready=%b", res_valid, job_ready); end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
        n_checks++; if (job_ready !== 1'b1 || res_valid !== 1'b0) begin n_fail++; $display("FAIL stall_release: got ready=%b valid=%b exp 1 0", job_ready, res_valid); end
    endtask

    task automatic test_spurious_finish;
        logic bad;
        bad = 0;
        spur_fin = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (job_ready !== 1'b1 || res_valid !== 1'b0 || inv_pulse !== 1'b0 || exp_pulse !== 1'b0) bad = 1;
        end
        spur_fin = 0;
        n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL idle_finish_ignored: got state change, ready=%b valid=%b", job_ready, res_valid); end
    endtask

    task automatic test_timeout;
        int n;
        logic seen;
        job_p = P1; job_q = Q1; job_msg = M1; job_mode = 0;
        @(negedge clk);
        n_checks++; if (t_job_ready !== 1'b1) begin n_fail++; $display("FAIL to_ready: got %b exp 1", t_job_ready); end
        t_job_valid = 1;
        @(negedge clk);
        t_job_valid = 0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); seen = t_inv_pulse; end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_inv_pulse: got %b exp 1", seen); end
        @(negedge clk);
        t_inv_fin = 1;
        @(negedge clk);
        n_checks++; if (t_exp_pulse !== 1'b0) begin n_fail++; $display("FAIL first_wait_ignored: got exp_pulse=%b exp 0", t_exp_pulse); end
        @(negedge clk);
        t_inv_fin = 0;
        n_checks++; if (t_exp_pulse !== 1'b1) begin n_fail++; $display("FAIL to_exp_pulse: got %b exp 1", t_exp_pulse); end
        n = 0;
        do begin @(negedge clk); n++; end while (!t_res_valid && n < 40);
        n_checks++; if (n - 1 !== 16) begin n_fail++; $display("FAIL to_wait_cycles: got %0d exp 16", n - 1); end
        n_checks++; if (t_res_error !== 1'b1) begin n_fail++; $display("FAIL to_res_error: got %b exp 1", t_res_error); end
        n_checks++; if (t_res_msg !== '0) begin n_fail++; $display("FAIL to_res_msg: got %0h exp 0", t_res_msg); end
        t_res_ready = 1;
        @(negedge clk);
        t_res_ready = 0;
        n_checks++; if (t_job_ready !== 1'b1) begin n_fail++; $display("FAIL to_release: got %b exp 1", t_job_ready); end
        t_job_valid = 1;
        @(negedge clk);
        t_job_valid = 0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); seen = t_inv_pulse; end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL to_cache_invalidated: got %b exp 1", seen); end
    endtask

    task automatic test_reset_mid;
        int n, lat, i0, e0;
        logic bad, seen;
        inv_delay = 40; exp_delay = 2;
        @(negedge clk);
        n = 0;
        while (!job_ready && n < 200) begin @(negedge clk); n++; end
        job_p = P1; job_q = Q1; job_mode = 1; job_msg = M2; job_valid = 1;
        @(negedge clk);
        job_valid = 0;
        seen = 0;
        for (int i = 0; i < 5 && !seen; i++) begin @(negedge clk); seen = inv_pulse; end
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL rm_inv_pulse: got %b exp 1", seen); end
        repeat (5) @(negedge clk);
        #1 reset_n = 0;
        #1;
        n_checks++; if (rsa_p !== '0 || rsa_msg_in !== '0 || rsa_ed !== 1'b0) begin n_fail++; $display("FAIL rm_async_operands: got p=%0h msg=%0h exp 0", rsa_p, rsa_msg_in); end
        n_checks++; if (job_ready !== 1'b1 || res_valid !== 1'b0 || res_msg !== '0) begin n_fail++; $display("FAIL rm_async_state: got ready=%b valid=%b", job_ready, res_valid); end
        repeat (2) @(negedge clk);
        reset_n = 1;
        e0 = exp_pulses;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid || exp_pulse || inv_pulse) bad = 1;
        end
        n_checks++; if (bad !== 1'b0 || exp_pulses !== e0) begin n_fail++; $display("FAIL rm_abandoned: got activity after reset, exp none"); end
        inv_delay = 3;
        i0 = inv_pulses;
        submit(P1, Q1, 1'b0, M3, lat);
        n_checks++; if (lat !== 9) begin n_fail++; $display("FAIL rm_rerun_latency: got %0d exp 9", lat); end
        n_checks++; if (inv_pulses - i0 !== 1) begin n_fail++; $display("FAIL rm_rerun_inverter: got %0d exp 1", inv_pulses - i0); end
        n_checks++; if (res_msg !== M3 * 256'd7 + 256'd3) begin n_fail++; $display("FAIL rm_rerun_res_msg: got %0h exp %0h", res_msg, M3 * 256'd7 + 256'd3); end
        res_ready = 1;
        @(negedge clk);
        res_ready = 0;
    endtask

    initial begin
        test_reset();
        test_first_and_hit();
        test_miss();
        test_back_to_back_stall();
        test_spurious_finish();
        test_timeout();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
